// File: rtl/ysyx_23060251_pkg.sv
// Shared types and constants for the ysyx_23060251 load/store unit.
// Used by lsu_axi and lsu_lane_align.
package ysyx_23060251_pkg;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } lsu_size_e;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b0000001,
        ST_RD_ADDR = 7'b0000010,
        ST_RD_DATA = 7'b0000100,
        ST_WR_REQ  = 7'b0001000,
        ST_WR_RESP = 7'b0010000,
        ST_WB      = 7'b0100000,
        ST_FAULT   = 7'b1000000
    } lsu_state_e;

    localparam logic [1:0] CAUSE_LOAD_MISALIGN  = 2'd0;
    localparam logic [1:0] CAUSE_STORE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_LOAD_ACCESS    = 2'd2;
    localparam logic [1:0] CAUSE_STORE_ACCESS   = 2'd3;

    // Width of the byte offset within one XLEN-wide bus beat.
    function automatic int unsigned lsu_off_w(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store data/strobe placement and
// load extraction with sign or zero extension.
module lsu_lane_align
    import ysyx_23060251_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    localparam int unsigned STRB_W = XLEN / 8,
    localparam int unsigned OFF_W  = lsu_off_w(XLEN)
) (
    input  lsu_size_e         size_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic              is_signed_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   load_buf_i,
    output logic [XLEN-1:0]   w_data_o,
    output logic [STRB_W-1:0] w_strb_o,
    output logic [XLEN-1:0]   load_data_o
);

    logic [STRB_W-1:0] size_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   keep_mask;
    logic              sign_bit;
    logic [OFF_W+2:0]  bit_shift;

    assign bit_shift = {offset_i, 3'b000};
    assign w_data_o  = store_data_i << bit_shift;
    assign w_strb_o  = size_mask << offset_i;
    assign shifted   = load_buf_i >> bit_shift;

    always_comb begin
        size_mask = '0;
        case (size_i)
            SIZE_BYTE: size_mask = STRB_W'(8'h01);
            SIZE_HALF: size_mask = STRB_W'(8'h03);
            SIZE_WORD: size_mask = STRB_W'(8'h0F);
            default:   size_mask = STRB_W'(8'hFF);
        endcase
    end

    // Extension is done by masking so the same logic works for XLEN 32 and 64.
    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                keep_mask = XLEN'(64'hFF);
                sign_bit  = shifted[7];
            end
            SIZE_HALF: begin
                keep_mask = XLEN'(64'hFFFF);
                sign_bit  = shifted[15];
            end
            SIZE_WORD: begin
                keep_mask = XLEN'(64'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        load_data_o = (shifted & keep_mask) | ((is_signed_i && sign_bit) ? ~keep_mask : '0);
    end

endmodule

// File: rtl/lsu_axi.sv
// MEM-stage load/store unit: one AXI-Lite read or write per request.
// Optional R/B error reporting is enabled by YSYX_23060251_LSU_ACCESS_FAULT_EN.
module lsu_axi
    import ysyx_23060251_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned STRB_W = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              M_valid_i,
    output logic              m_ready_o,
    input  logic              renMem_i,
    input  logic              wenMem_i,
    input  logic              wenReg_i,
    input  logic              wenCsr_i,
    input  logic              is_load_signed_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              wb_en_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              fault_o,
    output logic [1:0]        fault_cause_o,
    output logic              mst_ar_valid_o,
    output logic [ADDR_W-1:0] mst_ar_addr_o,
    input  logic              mst_ar_ready_i,
    input  logic              mst_r_valid_i,
    input  logic [XLEN-1:0]   mst_r_data_i,
    input  axi_resp_t         mst_r_resp_i,
    output logic              mst_r_ready_o,
    output logic              mst_aw_valid_o,
    output logic [ADDR_W-1:0] mst_aw_addr_o,
    input  logic              mst_aw_ready_i,
    output logic              mst_w_valid_o,
    output logic [XLEN-1:0]   mst_w_data_o,
    output logic [STRB_W-1:0] mst_w_strb_o,
    input  logic              mst_w_ready_i,
    input  logic              mst_b_valid_i,
    input  axi_resp_t         mst_b_resp_i,
    output logic              mst_b_ready_o
);

    localparam int unsigned OFF_W = lsu_off_w(XLEN);

    lsu_state_e        state_q, state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [XLEN-1:0]   load_buf_q, load_buf_d;
    logic              misaligned;
    logic              size_misaligned;
    logic [XLEN-1:0]   load_data;
    logic [OFF_W-1:0]  offset;

`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
    logic rd_err_q, rd_err_d;
    logic r_err, b_err;
    assign r_err = (mst_r_resp_i == AXI_RESP_SLVERR) || (mst_r_resp_i == AXI_RESP_DECERR);
    assign b_err = (mst_b_resp_i == AXI_RESP_SLVERR) || (mst_b_resp_i == AXI_RESP_DECERR);
`else
    logic unused_resp;
    assign unused_resp = ^{mst_r_resp_i, mst_b_resp_i};
`endif

    assign offset        = addr_i[OFF_W-1:0];
    assign mst_ar_addr_o = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mst_aw_addr_o = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        size_misaligned = 1'b0;
        case (size_i)
            2'd1:    size_misaligned = addr_i[0];
            2'd2:    size_misaligned = |addr_i[1:0];
            2'd3:    size_misaligned = |addr_i[2:0];
            default: size_misaligned = 1'b0;
        endcase
    end

    assign misaligned = (renMem_i | wenMem_i) & size_misaligned;

    lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .size_i       (lsu_size_e'(size_i)),
        .offset_i     (offset),
        .is_signed_i  (is_load_signed_i),
        .store_data_i (wdata_i),
        .load_buf_i   (load_buf_q),
        .w_data_o     (mst_w_data_o),
        .w_strb_o     (mst_w_strb_o),
        .load_data_o  (load_data)
    );

    always_comb begin
        state_d        = state_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        load_buf_d     = load_buf_q;
        mst_ar_valid_o = 1'b0;
        mst_r_ready_o  = 1'b0;
        mst_aw_valid_o = 1'b0;
        mst_w_valid_o  = 1'b0;
        mst_b_ready_o  = 1'b0;
        m_ready_o      = 1'b0;
        wb_en_o        = 1'b0;
        fault_o        = 1'b0;
        fault_cause_o  = CAUSE_LOAD_MISALIGN;
        rdata_o        = '0;
`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
        rd_err_d       = rd_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
                rd_err_d  = 1'b0;
`endif
                if (M_valid_i) begin
                    if (misaligned)              state_d = ST_FAULT;
                    else if (renMem_i)           state_d = ST_RD_ADDR;
                    else if (wenMem_i)           state_d = ST_WR_REQ;
                    else if (wenReg_i | wenCsr_i) state_d = ST_WB;
                end
            end
            ST_RD_ADDR: begin
                mst_ar_valid_o = 1'b1;
                if (mst_ar_ready_i) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                mst_r_ready_o = 1'b1;
                if (mst_r_valid_i) begin
                    load_buf_d = mst_r_data_i;
                    state_d    = ST_WB;
`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
                    rd_err_d = r_err;
                    if (r_err) state_d = ST_FAULT;
`endif
                end
            end
            // AW and W are independent; each valid falls after its own handshake.
            ST_WR_REQ: begin
                mst_aw_valid_o = !aw_done_q;
                mst_w_valid_o  = !w_done_q;
                aw_done_d      = aw_done_q | mst_aw_ready_i;
                w_done_d       = w_done_q | mst_w_ready_i;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR_RESP: begin
                mst_b_ready_o = 1'b1;
                if (mst_b_valid_i) begin
                    m_ready_o = 1'b1;
                    state_d   = ST_IDLE;
`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
                    if (b_err) begin
                        fault_o       = 1'b1;
                        fault_cause_o = CAUSE_STORE_ACCESS;
                    end
`endif
                end
            end
            ST_WB: begin
                wb_en_o   = 1'b1;
                m_ready_o = 1'b1;
                rdata_o   = renMem_i ? load_data : '0;
                state_d   = ST_IDLE;
            end
            ST_FAULT: begin
                m_ready_o     = 1'b1;
                fault_o       = 1'b1;
                fault_cause_o = wenMem_i ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
                if (rd_err_q) fault_cause_o = CAUSE_LOAD_ACCESS;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            load_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            load_buf_q <= load_buf_d;
        end
    end

`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rd_err_q <= 1'b0;
        else        rd_err_q <= rd_err_d;
    end
`endif

endmodule

// File: tb/tb_lsu_axi.sv
// Scoreboard bench for lsu_axi (XLEN=32) with a delay-configurable AXI-Lite slave.
// Expectations follow YSYX_23060251_LSU_ACCESS_FAULT_EN when it is defined.
`timescale 1ns/1ps
module tb_lsu_axi;
    import ysyx_23060251_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        M_valid_i = 1'b0;
    logic        m_ready_o;
    logic        renMem_i = 1'b0, wenMem_i = 1'b0, wenReg_i = 1'b0, wenCsr_i = 1'b0;
    logic        is_load_signed_i = 1'b0;
    logic [1:0]  size_i = 2'd0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        wb_en_o;
    logic [31:0] rdata_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic        mst_ar_valid_o, mst_ar_ready_i = 1'b0;
    logic [31:0] mst_ar_addr_o;
    logic        mst_r_valid_i = 1'b0, mst_r_ready_o;
    logic [31:0] mst_r_data_i = '0;
    axi_resp_t   mst_r_resp_i = AXI_RESP_OKAY;
    logic        mst_aw_valid_o, mst_aw_ready_i = 1'b0;
    logic [31:0] mst_aw_addr_o;
    logic        mst_w_valid_o, mst_w_ready_i = 1'b0;
    logic [31:0] mst_w_data_o;
    logic [3:0]  mst_w_strb_o;
    logic        mst_b_valid_i = 1'b0, mst_b_ready_o;
    axi_resp_t   mst_b_resp_i = AXI_RESP_OKAY;

    lsu_axi #(.XLEN(32), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .M_valid_i(M_valid_i), .m_ready_o(m_ready_o),
        .renMem_i(renMem_i), .wenMem_i(wenMem_i), .wenReg_i(wenReg_i), .wenCsr_i(wenCsr_i),
        .is_load_signed_i(is_load_signed_i), .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .wb_en_o(wb_en_o), .rdata_o(rdata_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_ready_i(mst_ar_ready_i),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i),
        .mst_r_ready_o(mst_r_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_ready_i(mst_aw_ready_i),
        .mst_w_valid_o(mst_w_valid_o), .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o),
        .mst_w_ready_i(mst_w_ready_i),
        .mst_b_valid_i(mst_b_valid_i), .mst_b_resp_i(mst_b_resp_i), .mst_b_ready_o(mst_b_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wb;
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] arQ[$];
    logic [35:0] wQ[$];
    exp_t        monE;
    int          total = 0;
    int          bad = 0;

    int          arDelay = 0, awDelay = 0, wDelay = 0, rDelay = 0, bDelay = 0;
    logic [31:0] rDataCfg = '0;
    axi_resp_t   rRespCfg = AXI_RESP_OKAY;
    axi_resp_t   bRespCfg = AXI_RESP_OKAY;
    int          arWait = 0, awWait = 0, wWait = 0, rWait = 0, bWait = 0;
    bit          rPending = 0, bPending = 0, awGot = 0, wGot = 0, wrSeen = 0;
    int          arValidCycles = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic void pushExp(input logic wb, input logic [31:0] rd, input logic f, input logic [1:0] c);
        exp_t e;
        e.wb = wb; e.rdata = rd; e.fault = f; e.cause = c;
        expQ.push_back(e);
    endfunction

    // Slave: drive at the falling edge, then book the handshakes the next rising edge will take.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            mst_ar_ready_i = 0; mst_aw_ready_i = 0; mst_w_ready_i = 0;
            mst_r_valid_i = 0; mst_b_valid_i = 0;
            rPending = 0; bPending = 0; awGot = 0; wGot = 0; wrSeen = 0;
            arWait = 0; awWait = 0; wWait = 0; rWait = 0; bWait = 0;
        end else begin
            mst_ar_ready_i = mst_ar_valid_o && (arWait >= arDelay);
            mst_aw_ready_i = mst_aw_valid_o && (awWait >= awDelay);
            mst_w_ready_i  = mst_w_valid_o && (wWait >= wDelay);
            mst_r_valid_i  = rPending && (rWait >= rDelay);
            mst_r_data_i   = rPending ? rDataCfg : 32'h0;
            mst_r_resp_i   = rRespCfg;
            mst_b_valid_i  = bPending && (bWait >= bDelay);
            mst_b_resp_i   = bRespCfg;
            #1;
            if (mst_r_valid_i && mst_r_ready_o) rPending = 0;
            else if (rPending) rWait++;
            if (mst_b_valid_i && mst_b_ready_o) begin
                bPending = 0;
                wrSeen = 0;
            end else if (bPending) bWait++;
            if (mst_ar_valid_o) arValidCycles++;
            if (mst_ar_valid_o && mst_ar_ready_i) begin
                checkOutput("ar_expected", arQ.size() != 0, 1);
                if (arQ.size() != 0) checkOutput("ar_addr", mst_ar_addr_o, arQ.pop_front());
                arWait = 0; rPending = 1; rWait = 0;
            end else if (mst_ar_valid_o) arWait++;
            if (!wrSeen && (mst_aw_valid_o || mst_w_valid_o)) begin
                wrSeen = 1;
                checkOutput("aw_w_together", {mst_aw_valid_o, mst_w_valid_o}, 2'b11);
            end
            if (wGot && !awGot) checkOutput("w_dropped_aw_held", {mst_aw_valid_o, mst_w_valid_o}, 2'b10);
            if (mst_aw_valid_o && mst_aw_ready_i) begin
                awGot = 1; awWait = 0;
            end else if (mst_aw_valid_o) awWait++;
            if (mst_w_valid_o && mst_w_ready_i) begin
                wGot = 1; wWait = 0;
                checkOutput("w_expected", wQ.size() != 0, 1);
                if (wQ.size() != 0) checkOutput("w_strb_data", {mst_w_strb_o, mst_w_data_o}, wQ.pop_front());
            end else if (mst_w_valid_o) wWait++;
            if (awGot && wGot) begin
                bPending = 1; bWait = 0; awGot = 0; wGot = 0;
            end
        end
    end

    // Monitor: every retire cycle is compared against the oldest expectation.
    always @(negedge clk_i) begin
        #2;
        if (rst_i && m_ready_o) begin
            checkOutput("retire_expected", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                monE = expQ.pop_front();
                checkOutput("wb_en", wb_en_o, monE.wb);
                checkOutput("rdata", rdata_o, monE.rdata);
                checkOutput("fault", fault_o, monE.fault);
                if (monE.fault) checkOutput("fault_cause", fault_cause_o, monE.cause);
            end
        end else if (rst_i && wb_en_o) begin
            checkOutput("wb_en_without_ready", m_ready_o, 1);
        end
    end

    task automatic applyStimulus(input string name, input logic ren, input logic wen, input logic wreg,
                                 input logic wcsr, input logic sgn, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wd, input int expLat);
        int  lat;
        bit  seen;
        @(posedge clk_i); #1;
        renMem_i = ren; wenMem_i = wen; wenReg_i = wreg; wenCsr_i = wcsr;
        is_load_signed_i = sgn; size_i = sz; addr_i = addr; wdata_i = wd;
        M_valid_i = 1;
        lat = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_i); #3;
            lat++;
            if (m_ready_o) seen = 1;
        end
        checkOutput({name, "_latency"}, seen ? lat : -1, expLat);
        @(posedge clk_i); #1;
        M_valid_i = 0; renMem_i = 0; wenMem_i = 0; wenReg_i = 0; wenCsr_i = 0;
        is_load_signed_i = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int arBefore;
        bit inRd;

        #12;
        checkOutput("reset_outputs",
            {m_ready_o, wb_en_o, fault_o, mst_ar_valid_o, mst_r_ready_o, mst_aw_valid_o,
             mst_w_valid_o, mst_b_ready_o, |rdata_o}, 9'h0);
        @(posedge clk_i); #2;
        rst_i = 1;

        rDataCfg = 32'h8100_0000; arQ.push_back(32'h8000_0000);
        pushExp(1, 32'hFFFF_FF81, 0, 2'd0);
        applyStimulus("lb_signed", 1, 0, 0, 0, 1, 2'd0, 32'h8000_0003, 32'h0, 4);

        rDataCfg = 32'h0000_AB00; arQ.push_back(32'h8000_0000);
        pushExp(1, 32'h0000_00AB, 0, 2'd0);
        applyStimulus("lbu", 1, 0, 0, 0, 0, 2'd0, 32'h8000_0001, 32'h0, 4);

        rDataCfg = 32'h8001_0000; arQ.push_back(32'h8000_0000);
        pushExp(1, 32'hFFFF_8001, 0, 2'd0);
        applyStimulus("lh_signed", 1, 0, 0, 0, 1, 2'd1, 32'h8000_0002, 32'h0, 4);

        rDataCfg = 32'h1234_F00D; arQ.push_back(32'h8000_0000);
        pushExp(1, 32'h0000_F00D, 0, 2'd0);
        applyStimulus("lhu", 1, 0, 0, 0, 0, 2'd1, 32'h8000_0000, 32'h0, 4);

        rDataCfg = 32'hDEAD_BEEF; arQ.push_back(32'h8000_0004);
        pushExp(1, 32'hDEAD_BEEF, 0, 2'd0);
        applyStimulus("lw", 1, 0, 0, 0, 1, 2'd2, 32'h8000_0004, 32'h0, 4);

        wQ.push_back({4'b1100, 32'h1234_0000});
        pushExp(0, 32'h0, 0, 2'd0);
        applyStimulus("sh", 0, 1, 0, 0, 0, 2'd1, 32'h8000_0002, 32'h0000_1234, 3);

        wQ.push_back({4'b0010, 32'h0000_A500});
        pushExp(0, 32'h0, 0, 2'd0);
        applyStimulus("sb", 0, 1, 0, 0, 0, 2'd0, 32'h8000_0001, 32'h0000_00A5, 3);

        awDelay = 3;
        wQ.push_back({4'b1111, 32'hCAFE_F00D});
        pushExp(0, 32'h0, 0, 2'd0);
        applyStimulus("sw_aw_slow", 0, 1, 0, 0, 0, 2'd2, 32'h8000_0008, 32'hCAFE_F00D, 6);
        awDelay = 0;

        pushExp(1, 32'h0, 0, 2'd0);
        applyStimulus("reg_wb", 0, 0, 1, 0, 0, 2'd2, 32'h8000_0001, 32'h0, 2);
        pushExp(1, 32'h0, 0, 2'd0);
        applyStimulus("csr_wb", 0, 0, 0, 1, 0, 2'd0, 32'h0, 32'h0, 2);

        arBefore = arValidCycles;
        pushExp(0, 32'h0, 1, CAUSE_LOAD_MISALIGN);
        applyStimulus("lw_misaligned", 1, 0, 0, 0, 0, 2'd2, 32'h8000_0002, 32'h0, 2);
        checkOutput("misaligned_no_ar", arValidCycles - arBefore, 0);

        pushExp(0, 32'h0, 1, CAUSE_STORE_MISALIGN);
        applyStimulus("sh_misaligned", 0, 1, 0, 0, 0, 2'd1, 32'h8000_0001, 32'h0000_5555, 2);

        rDataCfg = 32'h1122_3344; rRespCfg = AXI_RESP_SLVERR; arQ.push_back(32'h8000_0010);
`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
        pushExp(0, 32'h0, 1, CAUSE_LOAD_ACCESS);
`else
        pushExp(1, 32'h1122_3344, 0, 2'd0);
`endif
        applyStimulus("lw_slverr", 1, 0, 0, 0, 0, 2'd2, 32'h8000_0010, 32'h0, 4);
        rRespCfg = AXI_RESP_OKAY;

        bRespCfg = AXI_RESP_DECERR;
        wQ.push_back({4'b1111, 32'h0BAD_F00D});
`ifdef YSYX_23060251_LSU_ACCESS_FAULT_EN
        pushExp(0, 32'h0, 1, CAUSE_STORE_ACCESS);
`else
        pushExp(0, 32'h0, 0, 2'd0);
`endif
        applyStimulus("sw_decerr", 0, 1, 0, 0, 0, 2'd2, 32'h8000_0014, 32'h0BAD_F00D, 3);
        bRespCfg = AXI_RESP_OKAY;

        // Abort a load in RD_DATA with an asynchronous reset.
        rDelay = 20; rDataCfg = 32'h7777_7777; arQ.push_back(32'h8000_0030);
        @(posedge clk_i); #1;
        renMem_i = 1; size_i = 2'd2; addr_i = 32'h8000_0030; is_load_signed_i = 0; M_valid_i = 1;
        inRd = 0;
        for (int i = 0; i < 20 && !inRd; i++) begin
            @(negedge clk_i); #3;
            if (mst_r_ready_o) inRd = 1;
        end
        checkOutput("reached_rd_data", inRd, 1);
        @(posedge clk_i); #2;
        rst_i = 0;
        #1;
        checkOutput("async_reset_outputs",
            {m_ready_o, wb_en_o, fault_o, mst_ar_valid_o, mst_r_ready_o, mst_aw_valid_o,
             mst_w_valid_o, mst_b_ready_o, |rdata_o}, 9'h0);
        M_valid_i = 0; renMem_i = 0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1;
        rDelay = 0;

        rDataCfg = 32'h55AA_55AA; arQ.push_back(32'h8000_0020);
        pushExp(1, 32'h55AA_55AA, 0, 2'd0);
        applyStimulus("lw_after_reset", 1, 0, 0, 0, 0, 2'd2, 32'h8000_0020, 32'h0, 4);

        repeat (3) @(posedge clk_i);
        checkOutput("exp_queue_drained", expQ.size(), 0);
        checkOutput("ar_queue_drained", arQ.size(), 0);
        checkOutput("w_queue_drained", wQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_axi.md
# lsu_axi

Parametrised load/store unit for the MEM stage of the ysyx_23060251 core. It takes one memory or register-writeback request per M_valid_i/m_ready_o handshake. Memory requests become a single AXI-Lite read or write transaction, with byte-lane alignment, sign/zero extension and misalignment detection. AW and W are issued concurrently. Results go to the WB stage through a one-cycle wb_en_o strobe.

## Interface
Parameters:
- XLEN, 32: register and AXI data width; legal values 32 or 64.
- ADDR_W, 32: AXI address width.
- STRB_W, XLEN/8: write-strobe width; derived, not overridable.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; **asynchronous and active-low**.
- M_valid_i  in  1  request valid from MEM stage; all request inputs stable until m_ready_o.
- m_ready_o  out  1  request retired (writeback cycle or store B handshake).
- renMem_i / wenMem_i  in  1  load / store; never both high.
- wenReg_i / wenCsr_i  in  1  register/CSR writeback without memory access.
- is_load_signed_i  in  1  sign-extend load result.
- size_i  in  2  0 byte, 1 half, 2 word, 3 double (double legal only when XLEN=64).
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  XLEN  store data, LSB-justified.
- wb_en_o  out  1  one-cycle writeback strobe.
- rdata_o  out  XLEN  aligned, extended load result; valid while wb_en_o.
- fault_o  out  1  request faulted; valid with m_ready_o.
- fault_cause_o  out  2  0 load-misaligned, 1 store-misaligned, 2 load-access, 3 store-access.
- AXI-Lite master: mst_ar_{valid_o,addr_o,ready_i}, mst_r_{valid_i,data_i,resp_i,ready_o}, mst_aw_{valid_o,addr_o,ready_i}, mst_w_{valid_o,data_o,strb_o,ready_i}, mst_b_{valid_i,resp_i,ready_o}. Data is XLEN wide. Responses use axi_resp_t.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, WB, FAULT.
- IDLE transitions, in priority order:
  - misaligned memory request → FAULT;
  - renMem_i → RD_ADDR;
  - wenMem_i → WR_REQ;
  - wenReg_i|wenCsr_i → WB;
  - otherwise stay.
- Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0. No bus transaction is issued. m_ready_o=1, fault_o=1 for one cycle, then IDLE.
- RD_ADDR: mst_ar_valid_o=1; ar handshake → RD_DATA. Address is addr_i aligned down to XLEN/8 bytes.
- RD_DATA: mst_r_ready_o=1; r handshake latches data and resp into load_buf → WB.
- WR_REQ: mst_aw_valid_o and mst_w_valid_o are raised together. Each drops after its own handshake, tracked by aw_done/w_done flags. When both are done → WR_RESP. Handshakes may be simultaneous.
- WR_RESP: mst_b_ready_o=1; b handshake → IDLE with m_ready_o=1 in the same cycle.
- WB: wb_en_o=1 and m_ready_o=1 for one cycle → IDLE.
- Store lane placement: w_data = wdata_i << (8·offset). strb = size mask << offset, where offset = addr_i[log2(XLEN/8)-1:0].
- Load extraction: rdata_o = (load_buf >> 8·offset), truncated to the access size, then sign-extended if is_load_signed_i, else zero-extended. rdata_o is 0 for non-load writebacks.

## Timing
- Reset values: state IDLE; every valid/ready output 0; m_ready_o, wb_en_o and fault_o 0; load_buf 0; aw_done/w_done 0.
- Minimum latencies with zero-wait slaves:
  - load: 4 cycles (IDLE, RD_ADDR, RD_DATA, WB);
  - store: 3 cycles (IDLE, WR_REQ, WR_RESP);
  - register-only request: 2 cycles;
  - misaligned request: 2 cycles.
- Once asserted, a valid is held until its handshake. It never depends on ready.
- Reset asserted mid-transaction aborts immediately. Outstanding AXI beats are abandoned, and the interconnect is reset together with the LSU.
- M_valid_i dropping outside IDLE is illegal; behaviour is undefined.

## Configuration
- Macro: YSYX_23060251_LSU_ACCESS_FAULT_EN.
- Defined: an R or B resp of SLVERR/DECERR sets fault_o with cause 2/3 at m_ready_o. A faulted load suppresses wb_en_o, and the retire cycle stays in the FAULT path.
- Undefined: resp is ignored. Loads write back whatever data arrived, and fault_o is driven only by misalignment.

## Structure
- Shared package ysyx_23060251_pkg holds:
  - axi_resp_t;
  - lsu_size_e;
  - lsu_state_e (one-hot encoding);
  - fault-cause localparams;
  - the XLEN-dependent offset width.
- One combinational sub-module, lsu_lane_align, performs store shift/strobe generation and load extraction/extension. It is instantiated once and parametrised by XLEN.

## Test plan
- XLEN=32, signed lb at 0x8000_0003, R data 0x8100_0000 → AR addr 0x8000_0000, rdata_o 0xFFFF_FF81, wb_en_o one cycle.
- sh at 0x8000_0002, wdata 0x0000_1234 → w_data 0x1234_0000, strb 0b1100, AW and W valid in the same cycle.
- Store with aw_ready delayed 3 cycles and w_ready immediate → W handshakes first with w_valid dropping, AW held; B follows, then m_ready_o pulses once.
- lw at 0x8000_0002 → no AR valid ever; fault_o=1, cause 0, m_ready_o one cycle after request.
- Load returning SLVERR: with macro → fault_o=1, cause 2, no wb_en_o. Without macro → wb_en_o with data.
- rst_i low while in RD_DATA → all outputs 0 asynchronously. After release, the next lw completes normally.
